// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: converts the core's single-cycle data-memory access into a
// req/gnt/rvalid bus transaction, stalling the core until the transaction ends.
// Store data is lane-replicated with matching byte enables. Load data is aligned
// and extended. Misaligned or illegal accesses and bus timeouts finish in DONE
// with a one-cycle flag.
module lsu_bus_bridge #(
    parameter int unsigned TIMEOUT = 255,  // max REQ+WAIT cycles, 0 = never abort
    parameter int unsigned CNT_W   = 8     // must be able to hold TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] dataAdr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Counter value during the last cycle allowed in REQ+WAIT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic        access;
    logic        is_store;
    logic        req_legal;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_ext;
    logic        timeout_hit;
    logic        start;
    logic        capture;
    logic        abort;
    logic        flag_misalign;

    // A store wins when both memRead and memWrite are high.
    assign access   = memRead | memWrite;
    assign is_store = memWrite;

    // The core stalls for every cycle of an access except the retire (DONE) cycle.
    assign stall   = access & (state_q != S_DONE);
    assign bus_req = (state_q == S_REQ);

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Access legality: size alignment, and unsigned sizes exist only for loads.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        req_legal = 1'b0;
        case (funct3)
            3'b000:  req_legal = 1'b1;
            3'b001:  req_legal = ~dataAdr[0];
            3'b010:  req_legal = (dataAdr[1:0] == 2'b00);
            3'b100:  req_legal = ~is_store;
            3'b101:  req_legal = ~is_store & ~dataAdr[0];
            default: req_legal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = writeData;
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << dataAdr[1:0];
                wdata_d = {4{writeData[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {dataAdr[1], 1'b0};
                wdata_d = {2{writeData[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = writeData;
            end
        endcase
    end

    // Select the addressed lane of the response word and extend it.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (off_q)
            2'd0:    lane_b = bus_rdata[7:0];
            2'd1:    lane_b = bus_rdata[15:8];
            2'd2:    lane_b = bus_rdata[23:16];
            default: lane_b = bus_rdata[31:24];
        endcase
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h0, lane_b};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state logic and the one-cycle events that drive the registers.
    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        capture       = 1'b0;
        abort         = 1'b0;
        flag_misalign = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (req_legal) begin
                        start   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        flag_misalign = 1'b1;
                        state_d       = S_DONE;
                    end
                end
            end
            S_REQ: begin
                // A completion in the final allowed cycle still counts.
                if (bus_gnt && bus_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, timeout counter, latched payload, load result and pulse flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            readData  <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q <= state_d;

            if (state_q == S_IDLE) begin
                cnt_q <= '0;
            end else if (state_q == S_REQ || state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (start) begin
                f3_q      <= funct3;
                off_q     <= dataAdr[1:0];
                bus_we    <= is_store;
                bus_addr  <= {dataAdr[31:2], 2'b00};
                bus_be    <= be_d;
                bus_wdata <= wdata_d;
            end

            misalign <= flag_misalign;
            bus_err  <= abort;

            if (capture) begin
                readData <= bus_we ? 32'h0 : load_ext;
            end else if (abort || flag_misalign) begin
                readData <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Testbench for lsu_bus_bridge: directed transactions with a transaction-level
// model that derives per-cycle expectations, plus literal pins of key values.
module tb_lsu_bus_bridge;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] dataAdr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    lsu_bus_bridge #(
        .TIMEOUT(TB_TIMEOUT),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .dataAdr   (dataAdr),
        .writeData (writeData),
        .readData  (readData),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_gnt   (bus_gnt),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        bit ok_code;
        ok_code = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
        return ok_code && ((int'(a[1:0]) % size_of(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz, base;
        sz   = size_of(f3);
        base = int'(a[1:0]) - (int'(a[1:0]) % sz);
        return 4'(((1 << sz) - 1) << base);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v, mask;
        int sz, base;
        sz   = size_of(f3);
        base = int'(a[1:0]) - (int'(a[1:0]) % sz);
        v    = w >> (8 * base);
        if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            v    = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // ---------------- per-cycle expectations and compare ----------------
    string       tname;
    int          cyc;
    bit          exp_valid = 1'b0;
    logic        exp_stall, exp_req, exp_mis, exp_err, exp_chk_rd, exp_we;
    logic [31:0] exp_rd, exp_addr, exp_wdata;
    logic [3:0]  exp_be;

    int          cap_stall, cap_req;
    logic        cap_mis, cap_err;
    logic [31:0] cap_rd, cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    // Compare the DUT against the model once per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            check($sformatf("%s c%0d stall", tname, cyc), 32'(stall), 32'(exp_stall));
            check($sformatf("%s c%0d bus_req", tname, cyc), 32'(bus_req), 32'(exp_req));
            check($sformatf("%s c%0d misalign", tname, cyc), 32'(misalign), 32'(exp_mis));
            check($sformatf("%s c%0d bus_err", tname, cyc), 32'(bus_err), 32'(exp_err));
            if (exp_req) begin
                check($sformatf("%s c%0d bus_addr", tname, cyc), bus_addr, exp_addr);
                check($sformatf("%s c%0d bus_be", tname, cyc), 32'(bus_be), 32'(exp_be));
                check($sformatf("%s c%0d bus_wdata", tname, cyc), bus_wdata, exp_wdata);
                check($sformatf("%s c%0d bus_we", tname, cyc), 32'(bus_we), 32'(exp_we));
            end
            if (exp_chk_rd) begin
                check($sformatf("%s c%0d readData", tname, cyc), readData, exp_rd);
                cap_rd = readData;
            end
            if (bus_req) begin
                cap_req++;
                cap_addr  = bus_addr;
                cap_be    = bus_be;
                cap_wdata = bus_wdata;
            end
            if (stall)    cap_stall++;
            if (misalign) cap_mis = 1'b1;
            if (bus_err)  cap_err = 1'b1;
        end
    end

    // One access: gnt arrives in REQ cycle gnt_at (0 = never), rvalid rv_at
    // cycles later (0 = same cycle). Runs through DONE plus one idle cycle.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int gnt_at, input int rv_at, input logic [31:0] rdata);
        bit legal, tmo;
        int n, s, req_last;
        legal = model_legal(wr, f3, a);
        if (!legal) begin
            tmo = 1'b0; s = 1; req_last = 0;
        end else begin
            n        = (gnt_at == 0) ? (1 << 30) : gnt_at + rv_at;
            tmo      = (n > TB_TIMEOUT);
            s        = 1 + (tmo ? TB_TIMEOUT : n);
            req_last = (gnt_at == 0 || gnt_at > TB_TIMEOUT) ? TB_TIMEOUT : gnt_at;
        end
        tname = name;
        cap_stall = 0; cap_req = 0; cap_mis = 1'b0; cap_err = 1'b0;
        cap_rd = 32'hx; cap_addr = 32'hx; cap_be = 4'hx; cap_wdata = 32'hx;
        for (int k = 0; k <= s + 1; k++) begin
            memRead    = (k <= s) ? rd : 1'b0;
            memWrite   = (k <= s) ? wr : 1'b0;
            funct3     = f3;
            dataAdr    = a;
            writeData  = wd;
            bus_gnt    = (gnt_at != 0) && (k == gnt_at);
            bus_rvalid = (gnt_at != 0) && (k == gnt_at + rv_at);
            bus_rdata  = rdata;
            cyc        = k;
            exp_stall  = (k < s);
            exp_req    = legal && (k >= 1) && (k <= req_last);
            exp_mis    = (k == s) && !legal;
            exp_err    = (k == s) && tmo;
            exp_chk_rd = (k == s);
            exp_rd     = (!legal || tmo || wr) ? 32'h0 : model_load(f3, a, rdata);
            exp_addr   = a & ~32'h3;
            exp_be     = model_be(f3, a);
            exp_wdata  = model_wdata(f3, wd);
            exp_we     = wr;
            exp_valid  = 1'b1;
            @(posedge clk); #1;
        end
        exp_valid  = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'd0;
        dataAdr = 32'h0; writeData = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset stall", 32'(stall), 32'h0);
        check("reset bus_req", 32'(bus_req), 32'h0);
        check("reset bus_we", 32'(bus_we), 32'h0);
        check("reset bus_addr", bus_addr, 32'h0);
        check("reset bus_be", 32'(bus_be), 32'h0);
        check("reset bus_wdata", bus_wdata, 32'h0);
        check("reset readData", readData, 32'h0);
        check("reset misalign", 32'(misalign), 32'h0);
        check("reset bus_err", 32'(bus_err), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn("SW", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 1, 32'h0);
        check("SW lit be", 32'(cap_be), 32'hF);
        check("SW lit addr", cap_addr, 32'h100);
        check("SW lit wdata", cap_wdata, 32'hDEADBEEF);
        check("SW lit stall cycles", cap_stall, 3);

        run_txn("SB", 0, 1, 3'b000, 32'h103, 32'h000000A5, 1, 1, 32'h0);
        check("SB lit be", 32'(cap_be), 32'h8);
        check("SB lit wdata", cap_wdata, 32'hA5A5A5A5);
        check("SB lit addr", cap_addr, 32'h100);

        run_txn("LB", 1, 0, 3'b000, 32'h202, 32'h0, 1, 1, 32'h12F45678);
        check("LB lit readData", cap_rd, 32'hFFFFFFF4);
        run_txn("LBU", 1, 0, 3'b100, 32'h202, 32'h0, 1, 1, 32'h12F45678);
        check("LBU lit readData", cap_rd, 32'h000000F4);
        run_txn("LHU", 1, 0, 3'b101, 32'h202, 32'h0, 1, 1, 32'h12F45678);
        check("LHU lit readData", cap_rd, 32'h000012F4);
        run_txn("LH gnt+rvalid", 1, 0, 3'b001, 32'h200, 32'h0, 2, 0, 32'h00008001);
        check("LH lit readData", cap_rd, 32'hFFFF8001);
        run_txn("SH", 0, 1, 3'b001, 32'h106, 32'h1234ABCD, 1, 2, 32'h0);
        check("SH lit be", 32'(cap_be), 32'hC);
        run_txn("LW lane3 prep", 1, 0, 3'b010, 32'h104, 32'h0, 1, 1, 32'h89ABCDEF);

        run_txn("LW misaligned", 1, 0, 3'b010, 32'h102, 32'h0, 1, 1, 32'h55555555);
        check("LW mis lit req cycles", cap_req, 0);
        check("LW mis lit pulse", 32'(cap_mis), 32'h1);
        check("LW mis lit readData", cap_rd, 32'h0);
        check("LW mis lit stall cycles", cap_stall, 1);
        run_txn("funct3 011", 1, 0, 3'b011, 32'h100, 32'h0, 1, 1, 32'h0);
        run_txn("SB unsigned code", 0, 1, 3'b100, 32'h100, 32'h7, 1, 1, 32'h0);
        run_txn("LH odd", 1, 0, 3'b001, 32'h201, 32'h0, 1, 1, 32'h0);

        run_txn("LW no gnt", 1, 0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0);
        check("timeout lit bus_err", 32'(cap_err), 32'h1);
        check("timeout lit req cycles", cap_req, 4);
        check("timeout lit readData", cap_rd, 32'h0);
        run_txn("LW after timeout", 1, 0, 3'b010, 32'h300, 32'h0, 1, 1, 32'hCAFEF00D);
        check("post-timeout lit readData", cap_rd, 32'hCAFEF00D);
        run_txn("LW late rvalid", 1, 0, 3'b010, 32'h304, 32'h0, 3, 3, 32'h01020304);
        run_txn("LW last cycle", 1, 0, 3'b010, 32'h308, 32'h0, 2, 2, 32'h0BADC0DE);
        run_txn("rd+wr is store", 1, 1, 3'b000, 32'h401, 32'h000000C3, 1, 1, 32'hFFFFFFFF);
        run_txn("LW reload", 1, 0, 3'b010, 32'h500, 32'h0, 1, 1, 32'h76543210);

        // Reset while in WAIT; the response arrives the cycle after reset.
        memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; dataAdr = 32'h400;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; memRead = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
        @(negedge clk);
        check("rst-in-wait bus_req", 32'(bus_req), 32'h0);
        check("rst-in-wait stall", 32'(stall), 32'h0);
        check("rst-in-wait readData", readData, 32'h0);
        check("rst-in-wait misalign", 32'(misalign), 32'h0);
        check("rst-in-wait bus_err", 32'(bus_err), 32'h0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("late rvalid readData", readData, 32'h0);
        check("late rvalid misalign", 32'(misalign), 32'h0);
        check("late rvalid bus_err", 32'(bus_err), 32'h0);
        check("late rvalid stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        run_txn("LBU after rst", 1, 0, 3'b100, 32'h403, 32'h0, 1, 1, 32'h9A000000);
        check("after rst lit readData", cap_rd, 32'h0000009A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
